// File: rtl/rf_wport_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rf_wport_arbiter_if
// Description : Bundles the writeback request, long-latency result and
//               register-file write-port signals of rf_wport_arbiter.
//               slave  = arbiter side, master = pipeline / register-file side.
// Revision    : 1.0 - initial release
// ============================================================================
interface rf_wport_arbiter_if;
    // Writeback request
    logic        wb_valid;
    logic [3:0]  wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic [31:0] wb_pc;
    logic        wb_ready;
    // Long-latency result
    logic        lu_valid;
    logic [4:0]  lu_waddr;
    logic [31:0] lu_wdata;
    logic [31:0] lu_pc;
    logic        lu_ready;
    // Register-file write port and hazard mask
    logic [3:0]  rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] rf_pc;
    logic [31:0] pend_mask;

    modport slave (
        input  wb_valid, wb_we, wb_waddr, wb_wdata, wb_pc,
        input  lu_valid, lu_waddr, lu_wdata, lu_pc,
        output wb_ready, lu_ready,
        output rf_we, rf_waddr, rf_wdata, rf_pc, pend_mask
    );

    modport master (
        output wb_valid, wb_we, wb_waddr, wb_wdata, wb_pc,
        output lu_valid, lu_waddr, lu_wdata, lu_pc,
        input  wb_ready, lu_ready,
        input  rf_we, rf_waddr, rf_wdata, rf_pc, pend_mask
    );
endinterface
`default_nettype wire

// File: rtl/rf_wport_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_wport_arbiter
// Description : Shares the register-file write port between writeback
//               (pass-through) and a queued long-latency result source that
//               drains into idle write-port cycles. Exports a pending mask
//               of registers targeted by queued entries.
//               Optional macro RF_ARB_STARVE_EN enables the starvation guard
//               that stalls writeback once the queue head has waited
//               STARVE_LIMIT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wport_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic         clk,
    input  wire logic         resetn,
    rf_wport_arbiter_if.slave bus
);

    localparam int AW = $clog2(FIFO_DEPTH);

    // Reject illegal configurations at elaboration
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
        (STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_param_check
        $error("rf_wport_arbiter: illegal FIFO_DEPTH or STARVE_LIMIT");
    end

    // Queue state
    logic [AW:0]            r_wr_ptr;
    logic [AW:0]            r_rd_ptr;
    logic [FIFO_DEPTH-1:0]  r_vld;
    logic [4:0]             r_addr [FIFO_DEPTH];
    logic [31:0]            r_data [FIFO_DEPTH];
    logic [31:0]            r_pc   [FIFO_DEPTH];
    logic [31:0]            r_pend;

    logic                   w_empty;
    logic                   w_full;
    logic                   w_lu_ready;
    logic                   w_push;
    logic                   w_store;
    logic                   w_pop;
    logic                   w_force;
    logic                   w_wb;
    logic                   w_drain;
    logic [AW-1:0]          w_wr_idx;
    logic [AW-1:0]          w_rd_idx;
    logic [FIFO_DEPTH-1:0]  w_vld_nxt;
    logic [31:0]            w_pend_nxt;
    logic [4:0]             w_addr_nxt;

    assign w_wr_idx   = r_wr_ptr[AW-1:0];
    assign w_rd_idx   = r_rd_ptr[AW-1:0];
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (w_wr_idx == w_rd_idx);
    assign w_lu_ready = resetn && !w_full;
    assign w_push     = bus.lu_valid && w_lu_ready;
    // A result for r0 is consumed without ever occupying a slot
    assign w_store    = w_push && (bus.lu_waddr != 5'd0);

`ifdef RF_ARB_STARVE_EN
    logic [3:0] r_starve;

    assign w_force = !w_empty && (r_starve >= 4'(STARVE_LIMIT));

    // Count head losses; reset on any pop or while empty, saturate at 15
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_starve <= 4'd0;
        end else if (w_empty || w_pop) begin
            r_starve <= 4'd0;
        end else if (r_starve != 4'hf) begin
            r_starve <= r_starve + 4'd1;
        end
    end
`else
    // Without the guard writeback has strict priority
    assign w_force = 1'b0;
`endif

    assign w_wb    = !w_force && bus.wb_valid && (bus.wb_we != 4'd0);
    assign w_drain = !w_force && !w_wb && !w_empty;
    assign w_pop   = resetn && (w_force || w_drain);

    // Write-port mux: queue head, writeback, or nothing; all zero in reset
    always_comb begin
        bus.rf_we    = 4'd0;
        bus.rf_waddr = 5'd0;
        bus.rf_wdata = 32'd0;
        bus.rf_pc    = 32'd0;
        if (resetn) begin
            if (w_force || w_drain) begin
                bus.rf_we    = 4'hf;
                bus.rf_waddr = r_addr[w_rd_idx];
                bus.rf_wdata = r_data[w_rd_idx];
                bus.rf_pc    = r_pc[w_rd_idx];
            end else if (w_wb) begin
                bus.rf_we    = bus.wb_we;
                bus.rf_waddr = bus.wb_waddr;
                bus.rf_wdata = bus.wb_wdata;
                bus.rf_pc    = bus.wb_pc;
            end
        end
    end

    assign bus.wb_ready  = resetn && !w_force;
    assign bus.lu_ready  = w_lu_ready;
    assign bus.pend_mask = r_pend;

    // Next-cycle pending mask from the post-update slot contents, so that
    // duplicate destinations in the queue are handled correctly
    always_comb begin
        w_vld_nxt  = r_vld;
        w_pend_nxt = 32'd0;
        w_addr_nxt = 5'd0;
        if (w_pop) begin
            w_vld_nxt[w_rd_idx] = 1'b0;
        end
        if (w_store) begin
            w_vld_nxt[w_wr_idx] = 1'b1;
        end
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            w_addr_nxt = (w_store && (w_wr_idx == AW'(i))) ? bus.lu_waddr : r_addr[i];
            if (w_vld_nxt[i]) begin
                w_pend_nxt = w_pend_nxt | (32'd1 << w_addr_nxt);
            end
        end
    end

    // Queue pointers, slot valid bits and pending mask
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_vld    <= '0;
            r_pend   <= 32'd0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_vld  <= w_vld_nxt;
            r_pend <= w_pend_nxt;
        end
    end

    // Queue payload storage; contents are qualified by r_vld and pointers
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_addr[w_wr_idx] <= bus.lu_waddr;
            r_data[w_wr_idx] <= bus.lu_wdata;
            r_pc[w_wr_idx]   <= bus.lu_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_wport_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_wport_arbiter
// Description : Directed, table-driven bench for rf_wport_arbiter with
//               hand-written reset, starvation and mid-operation reset
//               sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wport_arbiter;

    logic clk;
    logic resetn;
    int   n_checks;
    int   n_errors;

    rf_wport_arbiter_if bus();

    rf_wport_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wv;
        logic [3:0]  wwe;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] wpc;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic [31:0] lpc;
        logic        e_wbr;
        logic        e_lur;
        logic [3:0]  e_we;
        logic [4:0]  e_a;
        logic [31:0] e_d;
        logic [31:0] e_pc;
        logic [31:0] e_pend;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic wv, input logic [3:0] wwe, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [31:0] wpc,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld,
                       input logic [31:0] lpc,
                       input logic e_wbr, input logic e_lur, input logic [3:0] e_we,
                       input logic [4:0] e_a, input logic [31:0] e_d,
                       input logic [31:0] e_pc, input logic [31:0] e_pend);
        vec_t v;
        v.wv = wv; v.wwe = wwe; v.wa = wa; v.wd = wd; v.wpc = wpc;
        v.lv = lv; v.la = la; v.ld = ld; v.lpc = lpc;
        v.e_wbr = e_wbr; v.e_lur = e_lur; v.e_we = e_we; v.e_a = e_a;
        v.e_d = e_d; v.e_pc = e_pc; v.e_pend = e_pend;
        vt.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive a full input set at the falling edge, then settle before sampling
    task automatic drive(input logic wv, input logic [3:0] wwe, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [31:0] wpc,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld,
                         input logic [31:0] lpc);
        @(negedge clk);
        bus.wb_valid = wv;  bus.wb_we = wwe; bus.wb_waddr = wa;
        bus.wb_wdata = wd;  bus.wb_pc = wpc;
        bus.lu_valid = lv;  bus.lu_waddr = la; bus.lu_wdata = ld; bus.lu_pc = lpc;
        #2;
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        //  wv wwe wa     wd        wpc       lv la      ld        lpc       wbr lur we    a      d         pc        pend
        add(0, 4'h0, 5'd0, 32'h0,    32'h0,   0, 5'd0,  32'h0,    32'h0,    1, 1, 4'h0, 5'd0,  32'h0,    32'h0,    32'h0);
        add(1, 4'hf, 5'd5, 32'h1234, 32'h100, 0, 5'd0,  32'h0,    32'h0,    1, 1, 4'hf, 5'd5,  32'h1234, 32'h100,  32'h0);
        add(1, 4'h3, 5'd6, 32'h55,   32'h104, 0, 5'd0,  32'h0,    32'h0,    1, 1, 4'h3, 5'd6,  32'h55,   32'h104,  32'h0);
        add(1, 4'h0, 5'd5, 32'h77,   32'h108, 0, 5'd0,  32'h0,    32'h0,    1, 1, 4'h0, 5'd0,  32'h0,    32'h0,    32'h0);
        add(0, 4'h0, 5'd0, 32'h0,    32'h0,   1, 5'd7,  32'hA5A5, 32'h200,  1, 1, 4'h0, 5'd0,  32'h0,    32'h0,    32'h0);
        add(0, 4'h0, 5'd0, 32'h0,    32'h0,   0, 5'd0,  32'h0,    32'h0,    1, 1, 4'hf, 5'd7,  32'hA5A5, 32'h200,  32'h80);
        add(0, 4'h0, 5'd0, 32'h0,    32'h0,   0, 5'd0,  32'h0,    32'h0,    1, 1, 4'h0, 5'd0,  32'h0,    32'h0,    32'h0);
        add(1, 4'hf, 5'd1, 32'h11,   32'h300, 1, 5'd8,  32'h8888, 32'h208,  1, 1, 4'hf, 5'd1,  32'h11,   32'h300,  32'h0);
        add(1, 4'hf, 5'd2, 32'h22,   32'h304, 1, 5'd9,  32'h9999, 32'h20c,  1, 1, 4'hf, 5'd2,  32'h22,   32'h304,  32'h100);
        add(1, 4'hf, 5'd3, 32'h33,   32'h308, 1, 5'd10, 32'hAAAA, 32'h210,  1, 0, 4'hf, 5'd3,  32'h33,   32'h308,  32'h300);
        add(0, 4'h0, 5'd0, 32'h0,    32'h0,   0, 5'd0,  32'h0,    32'h0,    1, 0, 4'hf, 5'd8,  32'h8888, 32'h208,  32'h300);
        add(0, 4'h0, 5'd0, 32'h0,    32'h0,   0, 5'd0,  32'h0,    32'h0,    1, 1, 4'hf, 5'd9,  32'h9999, 32'h20c,  32'h200);
        add(0, 4'h0, 5'd0, 32'h0,    32'h0,   1, 5'd0,  32'hDEAD, 32'h214,  1, 1, 4'h0, 5'd0,  32'h0,    32'h0,    32'h0);
        add(0, 4'h0, 5'd0, 32'h0,    32'h0,   1, 5'd4,  32'h4444, 32'h218,  1, 1, 4'h0, 5'd0,  32'h0,    32'h0,    32'h0);
        add(1, 4'h0, 5'd5, 32'h77,   32'h30c, 0, 5'd0,  32'h0,    32'h0,    1, 1, 4'hf, 5'd4,  32'h4444, 32'h218,  32'h10);
        add(0, 4'h0, 5'd0, 32'h0,    32'h0,   0, 5'd0,  32'h0,    32'h0,    1, 1, 4'h0, 5'd0,  32'h0,    32'h0,    32'h0);
        add(0, 4'h0, 5'd0, 32'h0,    32'h0,   1, 5'd11, 32'hB0B0, 32'h21c,  1, 1, 4'h0, 5'd0,  32'h0,    32'h0,    32'h0);
        add(0, 4'h0, 5'd0, 32'h0,    32'h0,   1, 5'd12, 32'hC0C0, 32'h220,  1, 1, 4'hf, 5'd11, 32'hB0B0, 32'h21c,  32'h800);
        add(0, 4'h0, 5'd0, 32'h0,    32'h0,   0, 5'd0,  32'h0,    32'h0,    1, 1, 4'hf, 5'd12, 32'hC0C0, 32'h220,  32'h1000);
        add(0, 4'h0, 5'd0, 32'h0,    32'h0,   0, 5'd0,  32'h0,    32'h0,    1, 1, 4'h0, 5'd0,  32'h0,    32'h0,    32'h0);

        // ---------------- Reset with requests pending ----------------
        resetn = 1'b0;
        bus.wb_valid = 1'b1; bus.wb_we = 4'hf; bus.wb_waddr = 5'd3;
        bus.wb_wdata = 32'h1111; bus.wb_pc = 32'h40;
        bus.lu_valid = 1'b1; bus.lu_waddr = 5'd3; bus.lu_wdata = 32'h2222; bus.lu_pc = 32'h44;
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        chk("rst_rf_we",    32'(bus.rf_we),    32'h0);
        chk("rst_rf_waddr", 32'(bus.rf_waddr), 32'h0);
        chk("rst_rf_wdata", bus.rf_wdata,      32'h0);
        chk("rst_rf_pc",    bus.rf_pc,         32'h0);
        chk("rst_wb_ready", 32'(bus.wb_ready), 32'h0);
        chk("rst_lu_ready", 32'(bus.lu_ready), 32'h0);
        chk("rst_pend",     bus.pend_mask,     32'h0);
        @(negedge clk);
        bus.wb_valid = 1'b0; bus.wb_we = 4'h0; bus.lu_valid = 1'b0;
        resetn = 1'b1;
        @(negedge clk); #2;
        chk("rel_lu_ready", 32'(bus.lu_ready), 32'h1);
        chk("rel_wb_ready", 32'(bus.wb_ready), 32'h1);
        chk("rel_pend",     bus.pend_mask,     32'h0);

        // ---------------- Table-driven cycle sequence ----------------
        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].wv, vt[i].wwe, vt[i].wa, vt[i].wd, vt[i].wpc,
                  vt[i].lv, vt[i].la, vt[i].ld, vt[i].lpc);
            chk($sformatf("v%0d_wb_ready", i), 32'(bus.wb_ready), 32'(vt[i].e_wbr));
            chk($sformatf("v%0d_lu_ready", i), 32'(bus.lu_ready), 32'(vt[i].e_lur));
            chk($sformatf("v%0d_rf_we", i),    32'(bus.rf_we),    32'(vt[i].e_we));
            chk($sformatf("v%0d_pend", i),     bus.pend_mask,     vt[i].e_pend);
            if (vt[i].e_we != 4'h0) begin
                chk($sformatf("v%0d_rf_waddr", i), 32'(bus.rf_waddr), 32'(vt[i].e_a));
                chk($sformatf("v%0d_rf_wdata", i), bus.rf_wdata,      vt[i].e_d);
                chk($sformatf("v%0d_rf_pc", i),    bus.rf_pc,         vt[i].e_pc);
            end
        end

        // ---------------- Starvation under continuous writeback ----------------
        drive(1'b1, 4'hf, 5'd1, 32'h5000, 32'h500, 1'b1, 5'd13, 32'hD13D, 32'h400);
        chk("stv_push_rf_waddr", 32'(bus.rf_waddr), 32'd1);
        for (int c = 1; c <= 4; c++) begin
            drive(1'b1, 4'hf, 5'd1, 32'h5000 + 32'(c), 32'h500, 1'b0, 5'd0, 32'h0, 32'h0);
            chk($sformatf("stv_c%0d_wb_ready", c), 32'(bus.wb_ready), 32'h1);
            chk($sformatf("stv_c%0d_rf_waddr", c), 32'(bus.rf_waddr), 32'd1);
            chk($sformatf("stv_c%0d_pend", c),     bus.pend_mask,     32'h2000);
        end
        drive(1'b1, 4'hf, 5'd1, 32'h5005, 32'h500, 1'b0, 5'd0, 32'h0, 32'h0);
`ifdef RF_ARB_STARVE_EN
        chk("stv_force_wb_ready", 32'(bus.wb_ready), 32'h0);
        chk("stv_force_rf_we",    32'(bus.rf_we),    32'hf);
        chk("stv_force_rf_waddr", 32'(bus.rf_waddr), 32'd13);
        chk("stv_force_rf_wdata", bus.rf_wdata,      32'hD13D);
        drive(1'b1, 4'hf, 5'd1, 32'h5006, 32'h500, 1'b0, 5'd0, 32'h0, 32'h0);
        chk("stv_resume_wb_ready", 32'(bus.wb_ready), 32'h1);
        chk("stv_resume_rf_waddr", 32'(bus.rf_waddr), 32'd1);
        chk("stv_resume_pend",     bus.pend_mask,     32'h0);
`else
        chk("stv_prio_wb_ready", 32'(bus.wb_ready), 32'h1);
        chk("stv_prio_rf_waddr", 32'(bus.rf_waddr), 32'd1);
        chk("stv_prio_rf_wdata", bus.rf_wdata,      32'h5005);
        idle();
        chk("stv_drain_rf_we",    32'(bus.rf_we),    32'hf);
        chk("stv_drain_rf_waddr", 32'(bus.rf_waddr), 32'd13);
        chk("stv_drain_rf_wdata", bus.rf_wdata,      32'hD13D);
        idle();
        chk("stv_after_pend", bus.pend_mask, 32'h0);
`endif

        // ---------------- Fill queue, then reset mid-operation ----------------
        drive(1'b1, 4'hf, 5'd2, 32'h6000, 32'h600, 1'b1, 5'd14, 32'hE0E0, 32'h410);
        drive(1'b1, 4'hf, 5'd2, 32'h6001, 32'h604, 1'b1, 5'd15, 32'hF0F0, 32'h414);
        drive(1'b1, 4'hf, 5'd2, 32'h6002, 32'h608, 1'b0, 5'd0,  32'h0,    32'h0);
        chk("mrst_full_pend",     bus.pend_mask,     32'hC000);
        chk("mrst_full_lu_ready", 32'(bus.lu_ready), 32'h0);
        #1 resetn = 1'b0;
        #1;
        chk("mrst_pend",     bus.pend_mask,     32'h0);
        chk("mrst_rf_we",    32'(bus.rf_we),    32'h0);
        chk("mrst_lu_ready", 32'(bus.lu_ready), 32'h0);
        chk("mrst_wb_ready", 32'(bus.wb_ready), 32'h0);
        @(negedge clk);
        bus.wb_valid = 1'b0; bus.wb_we = 4'h0; bus.lu_valid = 1'b0;
        resetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #2;
            chk($sformatf("mrst_after%0d_rf_we", c), 32'(bus.rf_we),    32'h0);
            chk($sformatf("mrst_after%0d_pend", c),  bus.pend_mask,     32'h0);
            chk($sformatf("mrst_after%0d_lu_rdy", c), 32'(bus.lu_ready), 32'h1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rf_wport_arbiter.md
# rf_wport_arbiter

Shares the single register-file write port between the pipeline writeback stage and a long-latency result source (divider/multiplier return path). Writeback results pass straight through. Long-latency results queue in a small FIFO and drain into idle write-port cycles. An optional starvation guard briefly stalls writeback so queued results cannot wait indefinitely. The block also exports a per-register pending mask, which issue logic uses for hazard checks.

## Interface
- `FIFO_DEPTH`, default 2: long-latency queue entries; power of two, ≥2.
- `STARVE_LIMIT`, default 4: cycles a non-empty queue head may lose arbitration before it is forced through; range 1–15.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `resetn` in 1: reset, asynchronous and active-low.
- `wb_valid` in 1: writeback request.
- `wb_we` in 4: writeback byte strobes.
- `wb_waddr` in 5: writeback destination register.
- `wb_wdata` in 32: writeback data.
- `wb_pc` in 32: writeback PC, for debug.
- `wb_ready` out 1: writeback accepted this cycle.
- `lu_valid` in 1: long-latency result valid.
- `lu_waddr` in 5: long-latency destination register.
- `lu_wdata` in 32: long-latency result.
- `lu_pc` in 32: long-latency PC, for debug.
- `lu_ready` out 1: queue can accept.
- `rf_we` out 4: register-file byte write enables.
- `rf_waddr` out 5: register-file write address.
- `rf_wdata` out 32: register-file write data.
- `rf_pc` out 32: PC of the granted write, drives the debug trace.
- `pend_mask` out 32: bit n set ⇔ some queued entry targets register n.

## Operation
- Queue: circular FIFO with pointers of width log2(FIFO_DEPTH)+1; full/empty are decided by the MSB compare.
- Push occurs on `lu_valid & lu_ready`. `lu_ready` = !full.
  - A push with `lu_waddr`==0 is accepted but not stored: it is discarded and no write occurs.
- Grant rule, evaluated each cycle:
  - **Force**: `starve_cnt` ≥ STARVE_LIMIT and queue non-empty. The queue head writes. `wb_ready`=0.
  - **WB**: otherwise, `wb_valid` with `wb_we`≠0. Writeback writes. `wb_ready`=1.
  - **Drain**: otherwise, queue non-empty. The head writes with `rf_we`=4'hf, then pops. `wb_ready`=1, so a `wb_we`==0 request is consumed.
  - **Idle**: otherwise, `rf_we`=0. `wb_ready`=1.
- `starve_cnt` (4 bits):
  - Cleared on any pop and while the queue is empty.
  - Incremented when the queue is non-empty and the head is not granted.
  - Saturates at 15.
- `pend_mask`: OR of one-hot(waddr) over all valid queue entries. The register is updated on the same edge as push and pop.
- Simultaneous push and pop when full: not allowed, because `lu_ready`=0 while full.
  - Simultaneous push and pop when not full is legal; the count is unchanged.
- Issue logic guarantees no WAW between writeback and queued entries, using `pend_mask`. The arbiter never reorders or compares addresses.

## Timing
- The `rf_*` outputs and `wb_ready` are combinational from the inputs and the queue head. The register file commits at the next `clk` edge, so writeback latency is 0 cycles.
- A pushed entry is visible at the queue head the cycle after the push. Its earliest write is that cycle.
- Worst-case wait at the queue head, with the guard enabled: STARVE_LIMIT cycles, then a forced grant.
- While `resetn`=0:
  - Queue emptied, `starve_cnt`=0, `pend_mask`=0.
  - `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `rf_pc`=0.
  - `wb_ready`=0, `lu_ready`=0.
- If reset asserts mid-operation, queued results are lost. Deassertion takes effect at the next `clk` edge.

## Configuration
- `RF_ARB_STARVE_EN` defined: the starvation guard and Force rule are as above.
- `RF_ARB_STARVE_EN` not defined:
  - `starve_cnt` is removed.
  - Writeback has strict priority, and the queue drains only in idle writeback cycles.
  - `wb_ready` is tied to 1 outside reset.

## Test plan
- **Reset**: hold `resetn`=0 while driving `wb_valid`=1 and `lu_valid`=1 → `rf_we`=0 and both ready outputs 0. After release, `lu_ready`=1 and `pend_mask`=0.
- **Writeback pass-through**: `wb_valid`=1, `wb_we`=4'hf, `wb_waddr`=5, `wb_wdata`=32'h1234 → same cycle `rf_we`=4'hf, `rf_waddr`=5, `rf_wdata`=32'h1234, `wb_ready`=1.
- **Drain on idle**: push `lu` addr 7 data 32'hA5A5 → next cycle `pend_mask`=32'h80. With `wb_valid`=0, `rf_waddr`=7 and `rf_we`=4'hf. The following cycle `pend_mask`=0.
- **Full queue**: push 2 entries while writeback is busy every cycle → `lu_ready`=0. A third `lu_valid` is not accepted, and `pend_mask` holds both bits.
- **Starvation**, guard enabled, STARVE_LIMIT=4: a queued entry sits under continuous writeback → on the 5th cycle after the push, `wb_ready`=0 and the queue head writes. Next cycle writeback resumes.
- **Zero destination and mid-operation reset**: a push to addr 0 → no write and no `pend_mask` bit. Then fill the queue and assert `resetn`=0 → queue empty and no further `rf_we`.
